reg_file_2w2r: RTL
==================

# reg_file_2w2r

Parametrised multi-port register file: generalises the current 8×8-bit, 2-read/1-write register file to configurable width and depth, adds a second write port with defined collision priority, optional write-to-read bypass, optional hardwired-zero register 0, and a sequenced clear engine. It sits in the CPU datapath between the decode stage (read addresses) and the writeback stage (write ports), and is also the board-test target driven from switches/keys.

## Interface
- DATA_W, 8, register width in bits
- ADDR_W, 3, address width; DEPTH = 2**ADDR_W registers
- ZERO_R0, 0, 1 = register 0 reads as 0 and ignores writes
- BYPASS, 1, 1 = read ports return same-cycle accepted write data

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- we3  in  1  write enable, port A
- wa3  in  ADDR_W  write address, port A
- wd3  in  DATA_W  write data, port A
- we4  in  1  write enable, port B (wins collisions)
- wa4  in  ADDR_W  write address, port B
- wd4  in  DATA_W  write data, port B
- ra1, ra2  in  ADDR_W  read addresses
- rd1, rd2  out  DATA_W  read data (combinational)
- clr_req  in  1  request to zero the whole array
- clr_busy  out  1  clear engine active
- clr_done  out  1  one-cycle pulse, clear finished
- wr_blocked  out  1  registered; high the cycle after any enabled write was dropped by the clear engine

## Operation
- Reset: all registers 0, FSM IDLE, clear counter 0, clr_busy=0, clr_done=0, wr_blocked=0. rst overrides every other input, including mid-clear.
- Writes (IDLE or DONE only): we3 → reg[wa3]<=wd3; we4 → reg[wa4]<=wd4. Both enabled, wa3==wa4 → only wd4 written.
- ZERO_R0=1: writes to address 0 discarded silently (not flagged); rd for address 0 is 0.
- Reads: rdN = reg[raN]. BYPASS=1: if raN matches an accepted write this cycle, rdN = that write data (port B over port A); bypass never applies to dropped writes or to address 0 when ZERO_R0=1. BYPASS=0: new data visible the cycle after the edge.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE: clr_req=1 → CLEAR, cnt<=0. Writes the same cycle are still accepted.
  - CLEAR: each edge reg[cnt]<=0, cnt<=cnt+1; on cnt==DEPTH-1 → DONE. All writes dropped; wr_blocked set next cycle if we3|we4. clr_req ignored.
  - DONE: clr_done=1, writes accepted, clr_req ignored; → IDLE next edge.
- Reads during CLEAR return current contents: already-cleared entries read 0, others old values.
- cnt is ADDR_W bits; wrap from DEPTH-1 is never used because FSM leaves CLEAR there.

## Timing
- Write latency: 1 edge to array; 0 cycles to rd with BYPASS=1.
- Read: combinational from raN and array.
- clr_req sampled high at edge k in IDLE: clr_busy=1 from k through k+DEPTH; entry i zeroed at edge k+1+i; clr_done=1 in cycle after edge k+DEPTH; IDLE after edge k+DEPTH+1. Total DEPTH+1 cycles busy-or-done.
- clr_busy is a Moore output (=state CLEAR); clr_done = state DONE.
- wr_blocked: registered, asserted exactly one cycle per cycle of dropped write.
- rst asserted at any edge → next cycle all outputs at reset values, array all zero.

## Test plan
- Reset then write port A wa3=5, wd3=8'hA5; same cycle ra1=5 → rd1=8'hA5 (BYPASS=1); next cycle ra2=5 → rd2=8'hA5.
- Collision: we3=we4=1, wa3=wa4=2, wd3=8'h11, wd4=8'h22 → rd1(ra1=2)=8'h22 same cycle and after edge; independent addresses 3/4 both written.
- ZERO_R0=1: write 8'hFF to address 0 → rd1(ra1=0)=0 before and after edge, wr_blocked stays 0.
- Fill all 8 registers with 8'h10+i, pulse clr_req → clr_busy high 8 cycles, reg i reads 0 from cycle after edge k+1+i, clr_done one-cycle pulse, then all reads 0.
- Write attempt (wa3=6, wd3=8'h77) during CLEAR → dropped, rd of 6 remains 0 after clear, wr_blocked=1 for one cycle; clr_req during CLEAR causes no restart.
- Assert rst at cycle 3 of CLEAR with registers pre-filled → next cycle all registers 0, clr_busy=0, clr_done never pulses.

Source files
------------

// File: rtl/reg_file_2w2r.sv
// Parametrised register file: two write ports (port B wins collisions), two
// combinational read ports with optional same-cycle bypass, and a sequenced clear engine.
module reg_file_2w2r #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 0,
  parameter int BYPASS  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic              we4,
  input  logic [ADDR_W-1:0] wa4,
  input  logic [DATA_W-1:0] wd4,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              wr_blocked
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, CLEAR, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              acc3;
  logic              acc4;

  // A write lands only outside CLEAR, and never on a hardwired-zero register 0.
  function automatic logic writable(input logic we, input logic [ADDR_W-1:0] wa);
    return we && !((ZERO_R0 != 0) && (wa == '0));
  endfunction

  function automatic logic [DATA_W-1:0] read_mux(input logic [ADDR_W-1:0] ra,
                                                 input logic [DATA_W-1:0] stored);
    if ((ZERO_R0 != 0) && (ra == '0)) return '0;
    if ((BYPASS != 0) && acc4 && (wa4 == ra)) return wd4;
    if ((BYPASS != 0) && acc3 && (wa3 == ra)) return wd3;
    return stored;
  endfunction

  assign acc3 = (state != CLEAR) && writable(we3, wa3);
  assign acc4 = (state != CLEAR) && writable(we4, wa4);

  always_comb begin
    rd1 = read_mux(ra1, mem[ra1]);
    rd2 = read_mux(ra2, mem[ra2]);
  end

  // Array update: port B assigned last so it wins an address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[cnt] <= '0;
    end else begin
      if (acc3) mem[wa3] <= wd3;
      if (acc4) mem[wa4] <= wd4;
    end
  end

  // Clear sequencer with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      clr_busy   <= 1'b0;
      clr_done   <= 1'b0;
      wr_blocked <= 1'b0;
    end else begin
      wr_blocked <= (state == CLEAR) && (we3 || we4);
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            cnt      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            state    <= DONE;
            clr_busy <= 1'b0;
            clr_done <= 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

endmodule
